coeff_loader: RTL and testbench
===============================

Name: coeff_loader

Overview:
Writer side of the filter coefficient memory. Accepts a framed byte stream from the MCU link and assembles 16-bit tap coefficients. Writes each coefficient into the coefficient RAM at address filter*TAPS + tap, which is the same layout the tap reader uses. Runtime EQ updates go through this block, so the coefficient ROM becomes a loadable RAM.

Parameters:
TAPS, 4, coefficients per filter; must be a power of two (address = filter << log2(TAPS) + tap)
NUM_FILTERS, 16, number of filter slots; header filter field >= NUM_FILTERS is an error
ADDR_W, 11, coefficient RAM address width (2048 entries)
DATA_W, 16, coefficient width; fixed at 2 bytes per coefficient

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
byte_in  in  8  incoming frame byte
byte_valid  in  1  byte_in valid
byte_ready  out  1  loader can accept byte this cycle
wr_en  out  1  one-cycle RAM write strobe
wr_addr  out  ADDR_W  RAM write address
wr_data  out  DATA_W  RAM write data
busy  out  1  frame in progress (state != IDLE)
done  out  1  one-cycle pulse: frame fully written
err  out  1  sticky frame error; cleared on next accepted valid header

Behaviour:
- Handshake: a byte is consumed on a rising clk edge where byte_valid & byte_ready.
- Frame format: header byte, then TAPS coefficients, each sent high byte first, then low byte.
- Header byte: [7:4] must be 0xA (magic); [3:0] is the filter number.
- Reset (async, reset=0): state=IDLE, tap counter=0, hi-byte reg=0, wr_en=0, wr_addr=0, wr_data=0, done=0, err=0, busy=0. byte_ready=1 after reset is released.
- States:
  - IDLE: ready=1. On a header with good magic and filter < NUM_FILTERS: latch filter, tap=0, clear err, go to HI. On a bad header: set err, stay in IDLE, byte discarded.
  - HI: ready=1. Latch byte as coefficient [15:8], go to LO.
  - LO: ready=1. Go to WRITE with wr_data={hi,byte} and wr_addr=filter*TAPS+tap registered on that edge.
  - WRITE: ready=0. wr_en=1 for exactly this cycle.
    - If tap==TAPS-1: pulse done this cycle, go to IDLE.
    - Otherwise: tap++, go to HI.
- Latency: wr_en is high in the cycle immediately after the low-byte handshake.
- Throughput: minimum 3 cycles per coefficient (HI, LO, WRITE).
- wr_addr and wr_data hold their last values outside WRITE.
- wr_en is never high outside WRITE.
- Gaps: byte_valid low in any state holds that state indefinitely; there is no timeout.
- Reset mid-frame: immediate abort. Coefficients already written stay in RAM; the next frame must start with a header.
- Tap counter is log2(TAPS) bits and does not wrap within a frame; it is cleared on header acceptance.
- Address arithmetic: filter zero-extended to ADDR_W, shifted left by log2(TAPS), tap added. No overflow at default parameters (max 15*4+3=63).
- err is unaffected by done. A bad header received while err is already set keeps err=1.

Optional Feature:
Macro COEFF_LOADER_CKSUM_EN.
- Defined:
  - After the last WRITE, go to state CKSUM instead of IDLE; ready=1 in CKSUM.
  - Expect one byte equal to the XOR of all frame bytes (header plus coefficient bytes).
  - Match: pulse done in the cycle after the checksum handshake, then go to IDLE.
  - Mismatch: set err, no done, go to IDLE.
  - Writes are already committed either way.
  - done does not pulse in the last WRITE cycle.
- Undefined: no CKSUM state; done pulses in the last WRITE cycle as described above.

Test Plan:
- Frame A3,12,34,56,78,9A,BC,DE,F0 with valid held high -> wr_en at addrs 12,13,14,15 with data 0x1234,0x5678,0x9ABC,0xDEF0. done pulses once, in the same cycle as the addr-15 write. err=0, busy=0 afterwards.
- Header 0x53 -> err=1, byte_ready stays 1, no wr_en, busy=0. A following valid frame A0,... -> err clears on header acceptance; writes go to addrs 0..3.
- Valid held high for a full frame -> byte_ready=0 exactly in each WRITE cycle; no byte lost or duplicated; 3 cycles per coefficient. Random valid gaps -> identical writes.
- Reset asserted after A1,11,22 -> outputs cleared asynchronously; exactly one write (addr 4, 0x1122) has occurred. Next frame A2,... writes to addrs 8..11 normally.
- NUM_FILTERS=8 build: header 0xA9 -> err=1, no writes.
- COEFF_LOADER_CKSUM_EN: first frame followed by checksum 0xA3 -> done pulses the cycle after that byte. Same frame with checksum 0x00 -> err=1, no done, all four writes still issued.

Source files
------------

// File: rtl/coeff_loader.sv
// Writer side of the coefficient RAM: assembles 16-bit taps from a framed byte stream.
// Optional trailing XOR checksum byte is enabled with `define COEFF_LOADER_CKSUM_EN.
module coeff_loader #(
    parameter int TAPS        = 4,
    parameter int NUM_FILTERS = 16,
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TAP_SH = $clog2(TAPS);
    localparam int TAP_W  = (TAP_SH > 0) ? TAP_SH : 1;

`ifdef COEFF_LOADER_CKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WRITE, S_CKSUM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_WRITE} state_t;
`endif

    state_t            state_q, state_d;
    logic [TAP_W-1:0]  tap_q;
    logic [3:0]        filter_q;
    logic [7:0]        hi_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              err_q;
    logic              hdr_ok;
    logic              accept_hdr, bad_hdr, ld_hi, ld_lo, tap_inc;
    logic [ADDR_W-1:0] addr_next;
`ifdef COEFF_LOADER_CKSUM_EN
    logic [7:0]        cksum_q;
    logic              done_q;
    logic              ck_ok, ck_bad;
`else
    logic              last_write;
`endif

    assign hdr_ok    = (byte_in[7:4] == 4'hA) && (32'(byte_in[3:0]) < 32'(NUM_FILTERS));
    assign addr_next = (ADDR_W'(filter_q) << TAP_SH) + ADDR_W'(tap_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b1;
        wr_en      = 1'b0;
        accept_hdr = 1'b0;
        bad_hdr    = 1'b0;
        ld_hi      = 1'b0;
        ld_lo      = 1'b0;
        tap_inc    = 1'b0;
`ifdef COEFF_LOADER_CKSUM_EN
        ck_ok      = 1'b0;
        ck_bad     = 1'b0;
`else
        last_write = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (byte_valid) begin
                    if (hdr_ok) begin
                        accept_hdr = 1'b1;
                        state_d    = S_HI;
                    end else begin
                        bad_hdr = 1'b1;
                    end
                end
            end
            S_HI: begin
                if (byte_valid) begin
                    ld_hi   = 1'b1;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (byte_valid) begin
                    ld_lo   = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                byte_ready = 1'b0;
                wr_en      = 1'b1;
                if (tap_q == TAP_W'(TAPS - 1)) begin
`ifdef COEFF_LOADER_CKSUM_EN
                    state_d = S_CKSUM;
`else
                    last_write = 1'b1;
                    state_d    = S_IDLE;
`endif
                end else begin
                    tap_inc = 1'b1;
                    state_d = S_HI;
                end
            end
`ifdef COEFF_LOADER_CKSUM_EN
            S_CKSUM: begin
                if (byte_valid) begin
                    ck_ok   = (byte_in == cksum_q);
                    ck_bad  = (byte_in != cksum_q);
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: header latch, byte assembly and the registered write beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap_q     <= '0;
            filter_q  <= '0;
            hi_q      <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept_hdr) begin
                filter_q <= byte_in[3:0];
                tap_q    <= '0;
                err_q    <= 1'b0;
            end
            if (bad_hdr) err_q <= 1'b1;
            if (ld_hi)   hi_q  <= byte_in;
            if (ld_lo) begin
                wr_data_q <= DATA_W'({hi_q, byte_in});
                wr_addr_q <= addr_next;
            end
            if (tap_inc) tap_q <= tap_q + 1'b1;
`ifdef COEFF_LOADER_CKSUM_EN
            if (ck_bad) err_q <= 1'b1;
`endif
        end
    end

`ifdef COEFF_LOADER_CKSUM_EN
    // Running XOR seeds with the header and folds in every coefficient byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cksum_q <= '0;
            done_q  <= 1'b0;
        end else begin
            if (accept_hdr)         cksum_q <= byte_in;
            else if (ld_hi | ld_lo) cksum_q <= cksum_q ^ byte_in;
            done_q <= ck_ok;
        end
    end
    assign done = done_q;
`else
    assign done = last_write;
`endif

    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_coeff_loader.sv
// Self-checking bench for coeff_loader: directed frames plus randomized frames/gaps
// compared against a frame-level reference model.
module tb_coeff_loader;
    localparam int TAPS = 4, NF = 16, ADDR_W = 11, DATA_W = 16;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready, wr_en, busy, done, err;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    coeff_loader #(.TAPS(TAPS), .NUM_FILTERS(NF), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int obs_a[$], obs_d[$], obs_w[$], obs_dn[$], hs_q[$];
    int ready_viol = 0;
    int exp_a[$], exp_d[$];
    int exp_done = 0;
    logic exp_err = 1'b0;

    always @(negedge clk) begin
        if (wr_en) begin
            obs_a.push_back(int'(wr_addr));
            obs_d.push_back(int'(wr_data));
            obs_w.push_back(cyc);
        end
        if (done) obs_dn.push_back(cyc);
        if (reset && (wr_en == byte_ready)) ready_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] xsum(input bq_t q, input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++) x ^= q[i];
        return x;
    endfunction

    // Reference: what a frame should produce in RAM, plus done/err outcome.
    task automatic model(input bq_t fr);
        int f = int'(fr[0][3:0]);
        exp_a.delete();
        exp_d.delete();
        if (fr[0][7:4] == 4'hA && f < NF) begin
            for (int t = 0; t < TAPS; t++) begin
                exp_a.push_back(f * TAPS + t);
                exp_d.push_back(int'(fr[1 + 2*t]) * 256 + int'(fr[2 + 2*t]));
            end
`ifdef COEFF_LOADER_CKSUM_EN
            exp_done = (fr[2*TAPS + 1] == xsum(fr, 2*TAPS + 1)) ? 1 : 0;
            exp_err  = (exp_done == 0);
`else
            exp_done = 1;
            exp_err  = 1'b0;
`endif
        end else begin
            exp_done = 0;
            exp_err  = 1'b1;
        end
    endtask

    function automatic bq_t make_frame(input logic [7:0] hdr, input bit rand_data);
        bq_t q;
        q.push_back(hdr);
        for (int i = 0; i < 2*TAPS; i++)
            q.push_back(rand_data ? 8'($urandom_range(0, 255)) : 8'h00);
        return q;
    endfunction

    // Called at a negedge; returns at the negedge following the last handshake.
    task automatic send(input bq_t fr, input int gap_max);
        hs_q.delete();
        for (int i = 0; i < fr.size(); i++) begin
            int  budget = 20;
            bit  got = 0;
            if (gap_max > 0) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
            end
            byte_valid = 1'b1;
            byte_in    = fr[i];
            while (!got && budget > 0) begin
                #1;
                if (byte_ready) begin
                    @(posedge clk);
                    @(negedge clk);
                    hs_q.push_back(cyc);
                    got = 1;
                end else begin
                    @(negedge clk);
                    budget--;
                end
            end
            if (!got) begin
                chk("handshake_timeout", 32'd0, 32'd1);
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic clear_obs();
        obs_a.delete(); obs_d.delete(); obs_w.delete(); obs_dn.delete();
        ready_viol = 0;
    endtask

    task automatic check_frame(input string tag, input int nbytes);
        int n;
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_nwrites"}, obs_a.size(), exp_a.size());
        n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), obs_a[i], exp_a[i]);
            chk($sformatf("%s_data%0d", tag, i), obs_d[i], exp_d[i]);
            if (hs_q.size() > 2*i + 2)
                chk($sformatf("%s_wcyc%0d", tag, i), obs_w[i], hs_q[2*i + 2]);
        end
        chk({tag, "_ndone"}, obs_dn.size(), exp_done);
        if (obs_dn.size() > 0 && exp_done > 0 && hs_q.size() == nbytes)
            chk({tag, "_done_cyc"}, obs_dn[0], hs_q[nbytes - 1]);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ready_only_low_in_write"}, ready_viol, 0);
        clear_obs();
    endtask

    task automatic add_cksum(inout bq_t fr, input bit corrupt);
`ifdef COEFF_LOADER_CKSUM_EN
        logic [7:0] x = xsum(fr, fr.size());
        fr.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
`else
        if (corrupt) fr = fr;
`endif
    endtask

    initial begin
        bq_t fr;
        // Reset state, sampled while reset is held
        #1;
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_ready", byte_ready, 1'b1);
        @(negedge clk);
        clear_obs();

        // Directed frame, valid held high
        fr = '{8'hA3, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        add_cksum(fr, 1'b0);
        model(fr);
        send(fr, 0);
        for (int i = 0; i + 1 < obs_w.size(); i++)
            chk($sformatf("a3_spacing%0d", i), obs_w[i+1] - obs_w[i], 3);
        check_frame("a3", fr.size());

        // Bad magic
        fr = '{8'h53};
        model(fr);
        send(fr, 0);
        #1;
        chk("bad_hdr_ready", byte_ready, 1'b1);
        check_frame("bad_hdr", 1);

        // Recovery frame to filter 0 with random gaps
        fr = make_frame(8'hA0, 1'b1);
        add_cksum(fr, 1'b0);
        model(fr);
        send(fr, 3);
        check_frame("a0_gaps", fr.size());

`ifdef COEFF_LOADER_CKSUM_EN
        // Wrong checksum: writes still committed, err instead of done
        fr = '{8'hA3, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
        model(fr);
        send(fr, 0);
        check_frame("ck_bad", fr.size());
`endif

        // Asynchronous reset in the middle of a frame
        fr = '{8'hA1, 8'h11, 8'h22};
        send(fr, 0);
        #1;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_en, 1'b0);
        chk("mid_rst_wr_addr", wr_addr, 32'd0);
        chk("mid_rst_wr_data", wr_data, 32'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_nwrites", obs_a.size(), 1);
        if (obs_a.size() > 0) begin
            chk("mid_rst_addr0", obs_a[0], 4);
            chk("mid_rst_data0", obs_d[0], 32'h1122);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_obs();
        fr = make_frame(8'hA2, 1'b1);
        add_cksum(fr, 1'b0);
        model(fr);
        send(fr, 0);
        check_frame("after_rst", fr.size());

        // Randomized frames, gaps and bad headers
        for (int k = 0; k < 25; k++) begin
            int kind = $urandom_range(0, 5);
            if (kind == 5) begin
                int m = $urandom_range(0, 15);
                if (m == 10) m = 5;
                fr = '{8'(m * 16 + $urandom_range(0, 15))};
            end else begin
                fr = make_frame(8'(8'hA0 + $urandom_range(0, NF - 1)), 1'b1);
                add_cksum(fr, $urandom_range(0, 3) == 0);
            end
            model(fr);
            send(fr, $urandom_range(0, 3));
            check_frame($sformatf("rnd%0d", k), fr.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
